// File: rtl/packer_pkg.sv
// Shared helpers for the narrow-to-wide packer: lane placement and counter sizing.
package packer_pkg;

  localparam bit ORDER_LSB_FIRST = 1'b0;
  localparam bit ORDER_MSB_FIRST = 1'b1;

  function automatic int sel_width(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Bit position of the low end of the lane that beat k occupies.
  function automatic int lane_lsb(input int k, input int in_w, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - k) * in_w : k * in_w;
  endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Output word register of the packer; owns valid_out/data_out and the upstream ready.
// Optional PACKER_FLUSH_EN adds the filled-beat count alongside the word.
module packer_out_reg #(
  parameter int OUT_W = 32
`ifdef PACKER_FLUSH_EN
  ,
  parameter int NB_W  = 3
`endif
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
`ifdef PACKER_FLUSH_EN
  input  logic [NB_W-1:0]  load_nb,
  output logic [NB_W-1:0]  nbytes_out,
`endif
  input  logic             ready_out,
  output logic             ready_in,
  output logic             valid_out,
  output logic [OUT_W-1:0] data_out
);

  logic             vld_p1;
  logic [OUT_W-1:0] data_p1;

  // A held word blocks the upstream side until the sink takes it.
  assign ready_in  = !vld_p1 || ready_out;
  assign valid_out = vld_p1;
  assign data_out  = data_p1;

  // stage p1: registered output word
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
    end else if (ready_out) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef PACKER_FLUSH_EN
  logic [NB_W-1:0] nb_p1;

  assign nbytes_out = nb_p1;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      nb_p1 <= '0;
    end else if (load) begin
      nb_p1 <= load_nb;
    end
  end
`endif

endmodule

// File: rtl/packer_nxm.sv
// Narrow-to-wide packer: gathers RATIO beats of IN_W bits into one word with valid/ready on both sides.
// Optional PACKER_FLUSH_EN adds flush_in/nbytes_out to emit a partially filled word.
module packer_nxm
  import packer_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST,
  localparam int OUT_W    = IN_W * RATIO
) (
  input  logic                       clk_4f,
  input  logic                       reset_L,
  input  logic                       valid_in,
  input  logic [IN_W-1:0]            data_in,
  output logic                       ready_in,
  output logic                       valid_out,
  output logic [OUT_W-1:0]           data_out,
  input  logic                       ready_out
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                       flush_in,
  output logic [$clog2(RATIO+1)-1:0] nbytes_out
`endif
);

  localparam int SEL_W = sel_width(RATIO);
  localparam int CNT_W = SEL_W + 1;

  logic [SEL_W-1:0] sel_p0;
  logic [OUT_W-1:0] acc_p0;
  logic [OUT_W-1:0] acc_merge;
  logic [CNT_W-1:0] fill_cnt;
  logic             accept;
  logic             last_beat;
  logic             load;

  assign accept    = valid_in && ready_in;
  assign last_beat = accept && (sel_p0 == SEL_W'(RATIO - 1));
  // Beats in the word once this cycle's beat (if any) is counted.
  assign fill_cnt  = {1'b0, sel_p0} + CNT_W'(accept);

  always_comb begin
    acc_merge = acc_p0;
    for (int k = 0; k < RATIO; k++) begin
      if (accept && (sel_p0 == SEL_W'(k))) begin
        acc_merge[lane_lsb(k, IN_W, RATIO, MSB_FIRST) +: IN_W] = data_in;
      end
    end
  end

`ifdef PACKER_FLUSH_EN
  localparam int NB_W = $clog2(RATIO + 1);

  logic            flush_fire;
  logic [NB_W-1:0] load_nb;

  // A flush arriving with the last beat is absorbed by the normal full word.
  assign flush_fire = flush_in && ready_in && !last_beat && (fill_cnt != '0);
  assign load       = last_beat || flush_fire;
  assign load_nb    = last_beat ? NB_W'(RATIO) : NB_W'(fill_cnt);
`else
  assign load = last_beat;
`endif

  // stage p0: lane counter and accumulator
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      sel_p0 <= '0;
      acc_p0 <= '0;
    end else if (load) begin
      sel_p0 <= '0;
      acc_p0 <= '0;
    end else if (accept) begin
      sel_p0 <= sel_p0 + SEL_W'(1);
      acc_p0 <= acc_merge;
    end
  end

  packer_out_reg #(
    .OUT_W(OUT_W)
`ifdef PACKER_FLUSH_EN
    ,
    .NB_W (NB_W)
`endif
  ) u_out_reg (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .load      (load),
    .load_data (acc_merge),
`ifdef PACKER_FLUSH_EN
    .load_nb   (load_nb),
    .nbytes_out(nbytes_out),
`endif
    .ready_out (ready_out),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

endmodule

// File: tb/tb_packer_nxm.sv
// Bench for packer_nxm: MSB-first and LSB-first instances share stimulus; a beat-queue model checks every cycle.
module tb_packer_nxm;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = 32;

  logic             clk_4f    = 1'b0;
  logic             reset_L   = 1'b0;
  logic             valid_in  = 1'b0;
  logic [IN_W-1:0]  data_in   = '0;
  logic             ready_out = 1'b1;
  logic             rdy_m, vld_m, rdy_l, vld_l;
  logic [OUT_W-1:0] dat_m, dat_l;
`ifdef PACKER_FLUSH_EN
  logic             flush_in  = 1'b0;
  logic [2:0]       nb_m, nb_l;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_4f = ~clk_4f;

  packer_nxm #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1'b1)) u_msb (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_in(rdy_m), .valid_out(vld_m), .data_out(dat_m), .ready_out(ready_out)
`ifdef PACKER_FLUSH_EN
    , .flush_in(flush_in), .nbytes_out(nb_m)
`endif
  );

  packer_nxm #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
    .ready_in(rdy_l), .valid_out(vld_l), .data_out(dat_l), .ready_out(ready_out)
`ifdef PACKER_FLUSH_EN
    , .flush_in(flush_in), .nbytes_out(nb_l)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: accepted beats are queued; a word is built from the queue with plain shifts.
  logic [IN_W-1:0]  beats[$];
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_word_m = '0;
  logic [OUT_W-1:0] m_word_l = '0;
  int               m_nb = 0;

  function automatic logic [OUT_W-1:0] pack(input bit msb);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < beats.size(); k++) begin
      if (msb) w = w | (OUT_W'(beats[k]) << (OUT_W - IN_W * (k + 1)));
      else     w = w | (OUT_W'(beats[k]) << (IN_W * k));
    end
    return w;
  endfunction

  initial begin
    bit rdy;
    forever begin
      @(negedge clk_4f);
      if (!reset_L) begin
        beats.delete();
        m_valid  = 1'b0;
        m_word_m = '0;
        m_word_l = '0;
        m_nb     = 0;
      end
      rdy = !m_valid || ready_out;
      chk("valid_msb", vld_m, m_valid);
      chk("valid_lsb", vld_l, m_valid);
      chk("data_msb", dat_m, m_word_m);
      chk("data_lsb", dat_l, m_word_l);
      chk("ready_msb", rdy_m, rdy);
      chk("ready_lsb", rdy_l, rdy);
`ifdef PACKER_FLUSH_EN
      chk("nbytes_msb", nb_m, m_nb);
      chk("nbytes_lsb", nb_l, m_nb);
`endif
      if (reset_L) begin
        if (m_valid && ready_out) m_valid = 1'b0;
        if (valid_in && rdy) beats.push_back(data_in);
        if (beats.size() == RATIO) begin
          m_word_m = pack(1'b1);
          m_word_l = pack(1'b0);
          m_nb     = RATIO;
          m_valid  = 1'b1;
          beats.delete();
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_in && rdy && beats.size() != 0) begin
          m_word_m = pack(1'b1);
          m_word_l = pack(1'b0);
          m_nb     = beats.size();
          m_valid  = 1'b1;
          beats.delete();
        end
`endif
      end
    end
  end

  // Presents a beat and returns #1 after the edge that accepted it; valid_in is left high.
  task automatic beat(input logic [IN_W-1:0] d);
    bit r;
    int n;
    n = 0;
    valid_in = 1'b1;
    data_in  = d;
    do begin
      @(negedge clk_4f);
      r = rdy_m;
      @(posedge clk_4f);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int cycles);
    valid_in = 1'b0;
    repeat (cycles) begin
      @(posedge clk_4f);
      #1;
    end
  endtask

  initial begin
    logic [OUT_W-1:0] t4_words[3];
    t4_words[0] = 32'hC0C1C2C3;
    t4_words[1] = 32'hC4C5C6C7;
    t4_words[2] = 32'hC8C9CACB;

    repeat (2) @(posedge clk_4f);
    #1;
    chk("rst_valid", vld_m, 1'b0);
    chk("rst_data", dat_m, 32'h0);
    chk("rst_ready", rdy_m, 1'b1);
    reset_L = 1'b1;
    idle(1);

    // Basic packing in both lane orders, one-cycle latency.
    beat(8'h01); beat(8'h02); beat(8'h03);
    chk("t1_pre_valid", vld_m, 1'b0);
    beat(8'h04);
    valid_in = 1'b0;
    chk("t1_valid", vld_m, 1'b1);
    chk("t1_word_msb", dat_m, 32'h01020304);
    chk("t2_word_lsb", dat_l, 32'h04030201);
    idle(1);
    chk("t1_drop", vld_m, 1'b0);

    // Sink stall holds the word and blocks the upstream side.
    ready_out = 1'b0;
    beat(8'hA1); beat(8'hA2); beat(8'hA3); beat(8'hA4);
    valid_in = 1'b1;
    data_in  = 8'hB1;
    repeat (5) begin
      @(posedge clk_4f);
      #1;
      chk("t3_stall_ready", rdy_m, 1'b0);
      chk("t3_hold", dat_m, 32'hA1A2A3A4);
    end
    ready_out = 1'b1;
    beat(8'hB1); beat(8'hB2); beat(8'hB3); beat(8'hB4);
    valid_in = 1'b0;
    chk("t3_word2", dat_m, 32'hB1B2B3B4);
    idle(2);

    // Twelve back-to-back beats yield three words.
    for (int i = 0; i < 12; i++) begin
      beat(8'hC0 + 8'(i));
      if ((i % 4) == 3) begin
        chk("t4_valid", vld_m, 1'b1);
        chk("t4_word", dat_m, t4_words[i / 4]);
      end
    end
    idle(2);

    // Input gap mid-word holds the partial word.
    beat(8'hD0);
    idle(3);
    beat(8'hD1); beat(8'hD2); beat(8'hD3);
    valid_in = 1'b0;
    chk("gap_word", dat_m, 32'hD0D1D2D3);
    idle(2);

    // Reset mid-word discards the partial.
    beat(8'h11); beat(8'h22);
    valid_in = 1'b0;
    reset_L  = 1'b0;
    @(posedge clk_4f);
    #1;
    chk("t5_rst_valid", vld_m, 1'b0);
    chk("t5_rst_data", dat_m, 32'h0);
    reset_L = 1'b1;
    idle(1);
    beat(8'h55); beat(8'h66); beat(8'h77); beat(8'h88);
    valid_in = 1'b0;
    chk("t5_word", dat_m, 32'h55667788);
    chk("t5_word_lsb", dat_l, 32'h88776655);
    idle(2);

`ifdef PACKER_FLUSH_EN
    // Flush of a two-beat partial word, then a full word from lane 0.
    beat(8'hAA); beat(8'hBB);
    valid_in = 1'b0;
    flush_in = 1'b1;
    @(posedge clk_4f);
    #1;
    flush_in = 1'b0;
    chk("t6_valid", vld_m, 1'b1);
    chk("t6_word", dat_m, 32'hAABB0000);
    chk("t6_word_lsb", dat_l, 32'h0000BBAA);
    chk("t6_nbytes", nb_m, 3'd2);
    beat(8'h01); beat(8'h02); beat(8'h03); beat(8'h04);
    valid_in = 1'b0;
    chk("t6_next_word", dat_m, 32'h01020304);
    chk("t6_next_nbytes", nb_m, 3'd4);
    flush_in = 1'b1;
    @(posedge clk_4f);
    #1;
    flush_in = 1'b0;
    chk("t6_empty_flush", vld_m, 1'b0);
    idle(2);
`endif

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
